// File: rtl/instruction_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode_if
// Description : Fetch, register-bank and execute-side signals of the MUSA
//               decode stage grouped into one bundle. The slave modport is
//               the decode stage; the master modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_decode_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // Fetch side
  logic                      if_valid;
  logic [31:0]               if_instr;
  logic [DATA_WIDTH-1:0]     if_pc;
  logic                      stall_out;
  logic                      flush;
  // Register bank read ports
  logic [REG_ADDR_WIDTH-1:0] address;
  logic [REG_ADDR_WIDTH-1:0] addressB;
  logic                      enable_read;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [DATA_WIDTH-1:0]     out_dataB;
  // ID/EX pipeline register contents
  logic                      ex_valid;
  logic [5:0]                ex_opcode;
  logic [5:0]                ex_funct;
  logic [DATA_WIDTH-1:0]     ex_rs_data;
  logic [DATA_WIDTH-1:0]     ex_rt_data;
  logic [DATA_WIDTH-1:0]     ex_imm;
  logic [25:0]               ex_jtarget;
  logic [REG_ADDR_WIDTH-1:0] ex_dest;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic [DATA_WIDTH-1:0]     ex_pc;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, out_data, out_dataB,
    output stall_out, address, addressB, enable_read,
    output ex_valid, ex_opcode, ex_funct, ex_rs_data, ex_rt_data, ex_imm,
    output ex_jtarget, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, out_data, out_dataB,
    input  stall_out, address, addressB, enable_read,
    input  ex_valid, ex_opcode, ex_funct, ex_rs_data, ex_rt_data, ex_imm,
    input  ex_jtarget, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc
  );
endinterface
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode
// Description : MUSA decode stage. Holds IF/ID, decodes control/immediate/
//               register fields, reads the register bank and fills ID/EX.
//               Inserts a single bubble on load-use hazards; execute-side
//               flush kills both pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  wire                   clock,
  input  wire                   reset,
  instruction_decode_if.slave   bus
);

  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_LW    = 6'h23;
  localparam logic [5:0] C_OP_SW    = 6'h2B;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_J     = 6'h02;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // IF/ID register
  logic                      r_id_valid;
  logic [31:0]               r_id_instr;
  logic [DATA_WIDTH-1:0]     r_id_pc;

  // ID/EX register
  logic                      r_ex_valid;
  logic [5:0]                r_ex_opcode;
  logic [5:0]                r_ex_funct;
  logic [DATA_WIDTH-1:0]     r_ex_rs_data;
  logic [DATA_WIDTH-1:0]     r_ex_rt_data;
  logic [DATA_WIDTH-1:0]     r_ex_imm;
  logic [25:0]               r_ex_jtarget;
  logic [REG_ADDR_WIDTH-1:0] r_ex_dest;
  logic                      r_ex_reg_write;
  logic                      r_ex_mem_read;
  logic                      r_ex_mem_write;
  logic [DATA_WIDTH-1:0]     r_ex_pc;

  // Instruction fields of the IF/ID entry
  logic [5:0]                w_opcode;
  logic [REG_ADDR_WIDTH-1:0] w_rs;
  logic [REG_ADDR_WIDTH-1:0] w_rt;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  logic [5:0]                w_funct;
  logic [15:0]               w_imm16;

  // Decoded controls
  logic [REG_ADDR_WIDTH-1:0] w_dest;
  logic                      w_writes;
  logic                      w_reg_write;
  logic                      w_mem_read;
  logic                      w_mem_write;
  logic                      w_rs_used;
  logic                      w_rt_used;

  logic                      w_load_use;
  logic                      w_stall;

  assign w_opcode = r_id_instr[31:26];
  assign w_rs     = r_id_instr[25:21];
  assign w_rt     = r_id_instr[20:16];
  assign w_rd     = r_id_instr[15:11];
  assign w_funct  = r_id_instr[5:0];
  assign w_imm16  = r_id_instr[15:0];

  // Register bank is addressed straight from the IF/ID instruction
  assign bus.address     = w_rs;
  assign bus.addressB    = w_rt;
  assign bus.enable_read = r_id_valid;

  // Opcode decode: destination, memory controls and which sources are read
  always_comb begin
    w_dest      = '0;
    w_writes    = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_rs_used   = 1'b0;
    w_rt_used   = 1'b0;
    case (w_opcode)
      C_OP_RTYPE: begin
        w_dest    = w_rd;
        w_writes  = 1'b1;
        w_rs_used = 1'b1;
        w_rt_used = 1'b1;
      end
      C_OP_ADDI: begin
        w_dest    = w_rt;
        w_writes  = 1'b1;
        w_rs_used = 1'b1;
      end
      C_OP_LW: begin
        w_dest     = w_rt;
        w_writes   = 1'b1;
        w_mem_read = 1'b1;
        w_rs_used  = 1'b1;
      end
      C_OP_SW: begin
        w_mem_write = 1'b1;
        w_rs_used   = 1'b1;
        w_rt_used   = 1'b1;
      end
      C_OP_BEQ: begin
        w_rs_used = 1'b1;
        w_rt_used = 1'b1;
      end
      C_OP_J: begin
        w_dest = '0;
      end
      default: begin
        w_dest = '0;
      end
    endcase
    // r0 is hardwired; a write to it is no write at all
    w_reg_write = w_writes & (w_dest != '0);
  end

  // A load sitting in ID/EX whose result is a source of the ID instruction
  assign w_load_use = r_id_valid & r_ex_valid & r_ex_mem_read & (r_ex_dest != '0) &
                      ((w_rs_used & (r_ex_dest == w_rs)) |
                       (w_rt_used & (r_ex_dest == w_rt)));

  // Hazard FSM: next state and stall request
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_RUN: begin
        w_stall = w_load_use;
        if (w_load_use) w_next_state = S_STALL;
      end
      S_STALL: begin
        w_next_state = S_RUN;
      end
      default: begin
        w_next_state = S_RUN;
      end
    endcase
    if (bus.flush) w_next_state = S_RUN;
  end

  assign bus.stall_out = w_stall;

  // Hazard FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_next_state;
  end

  // IF/ID register: flush kills it, a stall holds it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
    end else if (bus.flush) begin
      r_id_valid <= 1'b0;
    end else if (!w_stall) begin
      r_id_valid <= bus.if_valid;
      r_id_instr <= bus.if_instr;
      r_id_pc    <= bus.if_pc;
    end
  end

  // ID/EX register: decoded instruction or an all-zero bubble
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_opcode    <= '0;
      r_ex_funct     <= '0;
      r_ex_rs_data   <= '0;
      r_ex_rt_data   <= '0;
      r_ex_imm       <= '0;
      r_ex_jtarget   <= '0;
      r_ex_dest      <= '0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_pc        <= '0;
    end else if (bus.flush || w_stall || !r_id_valid) begin
      r_ex_valid     <= 1'b0;
      r_ex_opcode    <= '0;
      r_ex_funct     <= '0;
      r_ex_rs_data   <= '0;
      r_ex_rt_data   <= '0;
      r_ex_imm       <= '0;
      r_ex_jtarget   <= '0;
      r_ex_dest      <= '0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_pc        <= '0;
    end else begin
      r_ex_valid     <= 1'b1;
      r_ex_opcode    <= w_opcode;
      r_ex_funct     <= w_funct;
      r_ex_rs_data   <= bus.out_data;
      r_ex_rt_data   <= bus.out_dataB;
      r_ex_imm       <= {{(DATA_WIDTH-16){w_imm16[15]}}, w_imm16};
      r_ex_jtarget   <= r_id_instr[25:0];
      r_ex_dest      <= w_dest;
      r_ex_reg_write <= w_reg_write;
      r_ex_mem_read  <= w_mem_read;
      r_ex_mem_write <= w_mem_write;
      r_ex_pc        <= r_id_pc;
    end
  end

  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_opcode    = r_ex_opcode;
  assign bus.ex_funct     = r_ex_funct;
  assign bus.ex_rs_data   = r_ex_rs_data;
  assign bus.ex_rt_data   = r_ex_rt_data;
  assign bus.ex_imm       = r_ex_imm;
  assign bus.ex_jtarget   = r_ex_jtarget;
  assign bus.ex_dest      = r_ex_dest;
  assign bus.ex_reg_write = r_ex_reg_write;
  assign bus.ex_mem_read  = r_ex_mem_read;
  assign bus.ex_mem_write = r_ex_mem_write;
  assign bus.ex_pc        = r_ex_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_decode
// Description : Directed self-checking bench for instruction_decode with a
//               combinational register-bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register bank contents: r2 = 10, every other rN = 0x100 + N
  function automatic logic [31:0] bank_val(input logic [4:0] a);
    if (a == 5'd2) return 32'd10;
    return 32'h100 + {27'd0, a};
  endfunction

  // Bank read ports respond combinationally to the decode addresses
  always_comb begin
    bus.out_data  = bank_val(bus.address);
    bus.out_dataB = bank_val(bus.addressB);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst_stall", {31'd0, bus.stall_out}, 32'd0);
    check("rst_enable_read", {31'd0, bus.enable_read}, 32'd0);
    check("rst_address", {27'd0, bus.address}, 32'd0);
    reset = 1'b1;
    tick();

    // ADDI r5,r2,-4
    drive(1'b1, 32'h2045FFFC, 32'h100);
    tick();
    check("addi_address", {27'd0, bus.address}, 32'd2);
    check("addi_enable_read", {31'd0, bus.enable_read}, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("addi_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("addi_opcode", {26'd0, bus.ex_opcode}, 32'h08);
    check("addi_rs_data", bus.ex_rs_data, 32'd10);
    check("addi_imm", bus.ex_imm, 32'hFFFFFFFC);
    check("addi_dest", {27'd0, bus.ex_dest}, 32'd5);
    check("addi_reg_write", {31'd0, bus.ex_reg_write}, 32'd1);
    check("addi_mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
    check("addi_pc", bus.ex_pc, 32'h100);
    tick();
    check("idle_ex_valid", {31'd0, bus.ex_valid}, 32'd0);

    // ADD r7,r1,r2
    drive(1'b1, 32'h00223820, 32'h104);
    tick();
    check("add_address", {27'd0, bus.address}, 32'd1);
    check("add_addressB", {27'd0, bus.addressB}, 32'd2);
    check("add_enable_read", {31'd0, bus.enable_read}, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("add_funct", {26'd0, bus.ex_funct}, 32'h20);
    check("add_dest", {27'd0, bus.ex_dest}, 32'd7);
    check("add_reg_write", {31'd0, bus.ex_reg_write}, 32'd1);
    check("add_rs_data", bus.ex_rs_data, 32'h101);
    check("add_rt_data", bus.ex_rt_data, 32'd10);

    // LW r4,0(r1) then ADD r6,r4,r2: one-cycle stall
    drive(1'b1, 32'h8C240000, 32'h200);
    tick();
    drive(1'b1, 32'h00823020, 32'h204);
    tick();
    check("lu_stall", {31'd0, bus.stall_out}, 32'd1);
    check("lu_lw_mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
    check("lu_lw_dest", {27'd0, bus.ex_dest}, 32'd4);
    tick();
    check("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("lu_bubble_mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
    check("lu_stall_released", {31'd0, bus.stall_out}, 32'd0);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("lu_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("lu_add_rs_data", bus.ex_rs_data, 32'h104);
    check("lu_add_dest", {27'd0, bus.ex_dest}, 32'd6);
    check("lu_add_pc", bus.ex_pc, 32'h204);
    check("lu_no_restall", {31'd0, bus.stall_out}, 32'd0);

    // LW r0,0(r1) then ADD r6,r0,r2: no stall
    drive(1'b1, 32'h8C200000, 32'h300);
    tick();
    drive(1'b1, 32'h00023020, 32'h304);
    tick();
    check("r0_stall", {31'd0, bus.stall_out}, 32'd0);
    check("r0_lw_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
    check("r0_lw_mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("r0_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("r0_add_pc", bus.ex_pc, 32'h304);

    // LW r3 then ADDI r3,r3,1: genuine hazard on rs
    drive(1'b1, 32'h8C230000, 32'h400);
    tick();
    drive(1'b1, 32'h20630001, 32'h404);
    tick();
    check("addi_rs_hazard", {31'd0, bus.stall_out}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    // ADDI r3,r3,1 followed by itself: not a load, no stall
    drive(1'b1, 32'h20630001, 32'h500);
    tick();
    drive(1'b1, 32'h20630001, 32'h504);
    tick();
    check("self_rw_no_stall", {31'd0, bus.stall_out}, 32'd0);

    // Unknown opcode 0x3F decodes as a valid bubble
    drive(1'b1, 32'hFC000000, 32'h600);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("unk_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("unk_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
    check("unk_dest", {27'd0, bus.ex_dest}, 32'd0);
    tick();

    // Flush together with a load-use stall
    drive(1'b1, 32'h8C240000, 32'h700);
    tick();
    drive(1'b1, 32'h00823020, 32'h704);
    tick();
    check("fl_stall_before", {31'd0, bus.stall_out}, 32'd1);
    bus.flush = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    bus.flush = 1'b0;
    check("fl_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("fl_id_valid", {31'd0, bus.enable_read}, 32'd0);
    check("fl_stall", {31'd0, bus.stall_out}, 32'd0);
    check("fl_mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
    // State is RUN again: a fresh load-use stalls immediately
    drive(1'b1, 32'h8C240000, 32'h800);
    tick();
    drive(1'b1, 32'h00823020, 32'h804);
    tick();
    check("fl_run_restall", {31'd0, bus.stall_out}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Asynchronous reset mid-cycle with a live instruction in ID/EX
    drive(1'b1, 32'h2045FFFC, 32'h900);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("pre_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("async_opcode", {26'd0, bus.ex_opcode}, 32'd0);
    check("async_rs_data", bus.ex_rs_data, 32'd0);
    check("async_imm", bus.ex_imm, 32'd0);
    check("async_dest", {27'd0, bus.ex_dest}, 32'd0);
    check("async_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
    check("async_pc", bus.ex_pc, 32'd0);
    check("async_stall", {31'd0, bus.stall_out}, 32'd0);
    check("async_enable_read", {31'd0, bus.enable_read}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage of the MUSA core. Sits between instruction fetch and execute; drives the read ports of registers_bank.
- Holds the IF/ID pipeline register and decodes the 32-bit instruction into control, immediate and register addresses.
- Latches the register-bank read data into the ID/EX pipeline register.
- Detects load-use hazards, stalls fetch, and honours branch flushes from execute.

Parameters:
DATA_WIDTH, 32, operand/instruction/PC width
REG_ADDR_WIDTH, 5, register address width (32 registers)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
if_valid  input  1  fetch presents a valid instruction
if_instr  input  32  instruction word
if_pc  input  32  PC of if_instr
stall_out  output  1  fetch must hold if_instr/if_pc this cycle
flush  input  1  branch taken in execute; kill IF/ID and ID/EX contents
address  output  5  registers_bank port A read address (rs)
addressB  output  5  registers_bank port B read address (rt)
enable_read  output  1  registers_bank read enable
out_data  input  32  registers_bank port A data (combinational from address)
out_dataB  input  32  registers_bank port B data
ex_valid  output  1  ID/EX holds a real instruction
ex_opcode  output  6  opcode
ex_funct  output  6  funct field (R-type)
ex_rs_data  output  32  rs operand
ex_rt_data  output  32  rt operand
ex_imm  output  32  sign-extended instr[15:0]
ex_jtarget  output  26  instr[25:0]
ex_dest  output  5  destination register
ex_reg_write  output  1  writes a register
ex_mem_read  output  1  load
ex_mem_write  output  1  store
ex_pc  output  32  PC of instruction

Behaviour:
- Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
- Opcodes: R-type 6'h00, ADDI 6'h08, LW 6'h23, SW 6'h2B, BEQ 6'h04, J 6'h02. Any other opcode decodes as a bubble: all control flags 0, ex_valid still 1.
- Destination:
  - R-type: ex_dest=rd.
  - ADDI and LW: ex_dest=rt.
  - All others: ex_dest=0, reg_write=0.
  - reg_write is forced to 0 when dest==0.
- Reset (reset=0, async):
  - id_valid=0, ex_valid=0.
  - All ex_* outputs, address and addressB = 0; stall_out=0; enable_read=0.
  - State = RUN.
- IF/ID register:
  - Loads if_instr/if_pc/if_valid on each rising edge unless stall_out=1, in which case it holds.
- Register read:
  - address=rs and addressB=rt of the IF/ID instruction, combinationally.
  - enable_read = id_valid.
- ID/EX register:
  - Loads decoded fields plus out_data/out_dataB on each edge.
  - Loads a bubble (ex_valid=0, all control flags 0) when stalling.
- Latency: instruction sampled at edge N appears on ex_* after edge N+1.
- Hazard: load_use = id_valid & ex_valid & ex_mem_read & (ex_dest!=0) & (ex_dest==rs_used | ex_dest==rt_used).
  - rs is used by R-type, ADDI, LW, SW, BEQ.
  - rt is used by R-type, SW, BEQ.
- State machine:
  - RUN: stall_out=load_use. If load_use, go to STALL.
  - STALL: one bubble has been inserted and the hazard has cleared, so stall_out=0. Return to RUN.
  - Maximum stall per hazard is exactly 1 cycle.
- Flush:
  - At the next edge, id_valid=0, ex_valid=0 and all control flags 0. State returns to RUN.
  - Flush overrides stall when both are asserted in the same cycle.
- If if_valid=0, the IF/ID register captures id_valid=0. Downstream sees ex_valid=0 and control flags 0.
- An instruction that writes and reads the same register (e.g. ADDI r3,r3,1) does not cause a self-stall; only an LW already in ID/EX triggers a stall.

Test Plan:
1. Reset asserted mid-stream (reset=0 between edges) → ex_valid, stall_out and all ex_* outputs read 0 immediately, with no clock edge required.
2. ADDI r5,r2,-4 (0x2045FFFC), bank returns r2=10 → two edges later: ex_opcode=0x08, ex_rs_data=10, ex_imm=0xFFFFFFFC, ex_dest=5, ex_reg_write=1.
3. LW r4,0(r1) followed by ADD r6,r4,r2 → stall_out=1 for exactly one cycle, one bubble (ex_valid=0), then ADD enters ID/EX with ex_rs_data equal to the bank value of r4.
4. LW r0,0(r1) followed by ADD r6,r0,r2 → no stall (dest 0); LW with ex_reg_write=0.
5. flush and load_use asserted in the same cycle → next edge: ex_valid=0, id_valid=0, stall_out=0, state RUN.
6. R-type ADD r7,r1,r2 (0x00223820) → ex_funct=0x20, ex_dest=7, address=1, addressB=2, enable_read=1 while in ID.
